cdma_arb: RTL and testbench

- Multi-client descriptor arbiter and completion router placed in front of the unaligned CDMA top level.
- Shares the CDMA read descriptor port and write descriptor port among N_CLIENTS requesters, using independent round-robin arbitration per direction.
- Records the issuing client of each accepted descriptor in an in-order completion queue.
- Steers each CDMA done pulse back to the client that owns it.

---
 rtl/cdma_arb_pkg.sv | 14 +
 rtl/Q_srl.sv | 36 +++
 rtl/cdma_arb_dir.sv | 123 ++++++++++++
 rtl/cdma_arb.sv | 79 +++++++
 tb/tb_cdma_arb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdma_arb_pkg.sv
// Shared widths and descriptor layout for the CDMA client arbiter.
package cdma_arb_pkg;

    localparam int HBM_ADDR_BITS  = 33;
    localparam int HBM_LEN_BITS   = 32;
    localparam int CDMA_N_CLIENTS = 4;
    localparam int CDMA_CPL_DEPTH = 8;

    typedef struct packed {
        logic [HBM_LEN_BITS-1:0]  len;
        logic [HBM_ADDR_BITS-1:0] paddr;
    } cdma_desc_t;

endpackage

// File: rtl/Q_srl.sv
// In-order queue of client IDs; caller guarantees no push when full and no pop when empty.
module Q_srl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdma_arb_dir.sv
// One direction of the arbiter: round-robin grant, descriptor output register,
// completion ID queue and spurious-done flag.
module cdma_arb_dir #(
    parameter int N     = 4,
    parameter int AW    = 33,
    parameter int LW    = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N-1:0]    s_valid_i,
    output logic [N-1:0]    s_ready_o,
    input  logic [N*AW-1:0] s_paddr_i,
    input  logic [N*LW-1:0] s_len_i,
    output logic [N-1:0]    s_done_o,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic [AW-1:0]   m_paddr_o,
    output logic [LW-1:0]   m_len_o,
    input  logic            m_done_i,
    output logic            err_spurious_o
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic          m_valid_q;
    logic [AW-1:0] m_paddr_q;
    logic [LW-1:0] m_len_q;
    logic [N-1:0]  s_done_q;
    logic          err_q;

    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          slot_free;
    logic          accept;
    logic          pop;
    logic [IW-1:0] head_id;
    logic [N-1:0]  s_ready_d;
    logic [AW-1:0] sel_paddr;
    logic [LW-1:0] sel_len;

    // Walk offsets from farthest to nearest so the client right after ptr wins.
    always_comb begin
        int c;
        c       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            c = int'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (s_valid_i[IW'(c)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

    // Full check uses the pre-pop count, so a done never frees a slot in its own cycle.
    assign slot_free = (!m_valid_q || m_ready_i) && (cnt_q < CW'(DEPTH));
    assign accept    = gnt_any && slot_free;
    assign pop       = m_done_i && (cnt_q != '0);

    always_comb begin
        s_ready_d = '0;
        if (accept) s_ready_d[gnt_idx] = 1'b1;
    end

    always_comb begin
        int base_a;
        int base_l;
        base_a    = int'(gnt_idx) * AW;
        base_l    = int'(gnt_idx) * LW;
        sel_paddr = s_paddr_i[base_a +: AW];
        sel_len   = s_len_i[base_l +: LW];
    end

    Q_srl #(
        .DEPTH (DEPTH),
        .WIDTH (IW)
    ) u_cpl_q (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (accept),
        .data_i  (gnt_idx),
        .pop_i   (pop),
        .data_o  (head_id)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q     <= IW'(N - 1);
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_paddr_q <= '0;
            m_len_q   <= '0;
            s_done_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                m_valid_q <= 1'b1;
                m_paddr_q <= sel_paddr;
                m_len_q   <= sel_len;
                ptr_q     <= gnt_idx;
            end else if (m_ready_i) begin
                m_valid_q <= 1'b0;
            end
            cnt_q    <= cnt_q + CW'(accept) - CW'(pop);
            s_done_q <= '0;
            if (pop) s_done_q[head_id] <= 1'b1;
            if (m_done_i && (cnt_q == '0)) err_q <= 1'b1;
        end
    end

    assign s_ready_o      = s_ready_d;
    assign s_done_o       = s_done_q;
    assign m_valid_o      = m_valid_q;
    assign m_paddr_o      = m_paddr_q;
    assign m_len_o        = m_len_q;
    assign err_spurious_o = err_q;

endmodule

// File: rtl/cdma_arb.sv
// Multi-client descriptor arbiter and completion router in front of the CDMA;
// read and write directions are independent instances of the same path.
module cdma_arb
    import cdma_arb_pkg::*;
#(
    parameter int N_CLIENTS = CDMA_N_CLIENTS,
    parameter int ADDR_BITS = HBM_ADDR_BITS,
    parameter int LEN_BITS  = HBM_LEN_BITS,
    parameter int CPL_DEPTH = CDMA_CPL_DEPTH
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_CLIENTS-1:0]          s_rd_valid,
    output logic [N_CLIENTS-1:0]          s_rd_ready,
    input  logic [N_CLIENTS*ADDR_BITS-1:0] s_rd_paddr,
    input  logic [N_CLIENTS*LEN_BITS-1:0]  s_rd_len,
    output logic [N_CLIENTS-1:0]          s_rd_done,
    input  logic [N_CLIENTS-1:0]          s_wr_valid,
    output logic [N_CLIENTS-1:0]          s_wr_ready,
    input  logic [N_CLIENTS*ADDR_BITS-1:0] s_wr_paddr,
    input  logic [N_CLIENTS*LEN_BITS-1:0]  s_wr_len,
    output logic [N_CLIENTS-1:0]          s_wr_done,
    output logic                          m_rd_valid,
    input  logic                          m_rd_ready,
    output logic [ADDR_BITS-1:0]          m_rd_paddr,
    output logic [LEN_BITS-1:0]           m_rd_len,
    input  logic                          m_rd_done,
    output logic                          m_wr_valid,
    input  logic                          m_wr_ready,
    output logic [ADDR_BITS-1:0]          m_wr_paddr,
    output logic [LEN_BITS-1:0]           m_wr_len,
    input  logic                          m_wr_done,
    output logic                          err_rd_spurious,
    output logic                          err_wr_spurious
);

    cdma_arb_dir #(
        .N     (N_CLIENTS),
        .AW    (ADDR_BITS),
        .LW    (LEN_BITS),
        .DEPTH (CPL_DEPTH)
    ) u_rd (
        .clk_i          (aclk),
        .rst_n_i        (aresetn),
        .s_valid_i      (s_rd_valid),
        .s_ready_o      (s_rd_ready),
        .s_paddr_i      (s_rd_paddr),
        .s_len_i        (s_rd_len),
        .s_done_o       (s_rd_done),
        .m_valid_o      (m_rd_valid),
        .m_ready_i      (m_rd_ready),
        .m_paddr_o      (m_rd_paddr),
        .m_len_o        (m_rd_len),
        .m_done_i       (m_rd_done),
        .err_spurious_o (err_rd_spurious)
    );

    cdma_arb_dir #(
        .N     (N_CLIENTS),
        .AW    (ADDR_BITS),
        .LW    (LEN_BITS),
        .DEPTH (CPL_DEPTH)
    ) u_wr (
        .clk_i          (aclk),
        .rst_n_i        (aresetn),
        .s_valid_i      (s_wr_valid),
        .s_ready_o      (s_wr_ready),
        .s_paddr_i      (s_wr_paddr),
        .s_len_i        (s_wr_len),
        .s_done_o       (s_wr_done),
        .m_valid_o      (m_wr_valid),
        .m_ready_i      (m_wr_ready),
        .m_paddr_o      (m_wr_paddr),
        .m_len_o        (m_wr_len),
        .m_done_i       (m_wr_done),
        .err_spurious_o (err_wr_spurious)
    );

endmodule

// File: tb/tb_cdma_arb.sv
// Directed bench for cdma_arb: single issue, round robin, back-pressure,
// full queue, spurious done and mid-flight reset.
module tb_cdma_arb;
    import cdma_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = HBM_ADDR_BITS;
    localparam int LW = HBM_LEN_BITS;

    logic            clk;
    logic            aresetn;
    logic [N-1:0]    s_rd_valid, s_rd_ready, s_rd_done;
    logic [N*AW-1:0] s_rd_paddr;
    logic [N*LW-1:0] s_rd_len;
    logic [N-1:0]    s_wr_valid, s_wr_ready, s_wr_done;
    logic [N*AW-1:0] s_wr_paddr;
    logic [N*LW-1:0] s_wr_len;
    logic            m_rd_valid, m_rd_ready, m_rd_done;
    logic [AW-1:0]   m_rd_paddr;
    logic [LW-1:0]   m_rd_len;
    logic            m_wr_valid, m_wr_ready, m_wr_done;
    logic [AW-1:0]   m_wr_paddr;
    logic [LW-1:0]   m_wr_len;
    logic            err_rd_spurious, err_wr_spurious;

    int errors = 0;
    int checks = 0;

    cdma_arb dut (
        .aclk            (clk),
        .aresetn         (aresetn),
        .s_rd_valid      (s_rd_valid),
        .s_rd_ready      (s_rd_ready),
        .s_rd_paddr      (s_rd_paddr),
        .s_rd_len        (s_rd_len),
        .s_rd_done       (s_rd_done),
        .s_wr_valid      (s_wr_valid),
        .s_wr_ready      (s_wr_ready),
        .s_wr_paddr      (s_wr_paddr),
        .s_wr_len        (s_wr_len),
        .s_wr_done       (s_wr_done),
        .m_rd_valid      (m_rd_valid),
        .m_rd_ready      (m_rd_ready),
        .m_rd_paddr      (m_rd_paddr),
        .m_rd_len        (m_rd_len),
        .m_rd_done       (m_rd_done),
        .m_wr_valid      (m_wr_valid),
        .m_wr_ready      (m_wr_ready),
        .m_wr_paddr      (m_wr_paddr),
        .m_wr_len        (m_wr_len),
        .m_wr_done       (m_wr_done),
        .err_rd_spurious (err_rd_spurious),
        .err_wr_spurious (err_wr_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        s_rd_paddr[i*AW +: AW] = a;
        s_rd_len[i*LW +: LW]   = l;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        s_wr_paddr[i*AW +: AW] = a;
        s_wr_len[i*LW +: LW]   = l;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_rd_valid = '0; s_wr_valid = '0;
        s_rd_paddr = '0; s_rd_len = '0; s_wr_paddr = '0; s_wr_len = '0;
        m_rd_ready = 1'b0; m_wr_ready = 1'b0; m_rd_done = 1'b0; m_wr_done = 1'b0;
        step(); step();
        checks++;
        if ({m_rd_valid, m_wr_valid, s_rd_done, s_wr_done, err_rd_spurious, err_wr_spurious,
             s_rd_ready, s_wr_ready} !== '0 || m_rd_paddr !== '0 || m_wr_len !== '0) begin
            $display("FAIL reset_outputs got rv=%b wv=%b rd_done=%b wr_done=%b err=%b%b exp all 0",
                     m_rd_valid, m_wr_valid, s_rd_done, s_wr_done, err_rd_spurious, err_wr_spurious);
            errors++;
        end
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        set_rd(2, AW'(33'h1000), LW'(256));
        s_rd_valid = 4'b0100;
        #1;
        checks++;
        if (s_rd_ready !== 4'b0100 || m_rd_valid !== 1'b0) begin
            $display("FAIL single_grant got ready=%b valid=%b exp ready=0100 valid=0", s_rd_ready, m_rd_valid);
            errors++;
        end
        step();
        s_rd_valid = '0;
        checks++;
        if (m_rd_valid !== 1'b1 || m_rd_paddr !== AW'(33'h1000) || m_rd_len !== LW'(256)) begin
            $display("FAIL single_issue got v=%b a=%0h l=%0d exp v=1 a=1000 l=256", m_rd_valid, m_rd_paddr, m_rd_len);
            errors++;
        end
        m_rd_ready = 1'b1;
        step();
        m_rd_ready = 1'b0;
        checks++;
        if (m_rd_valid !== 1'b0) begin
            $display("FAIL single_drop got v=%b exp 0", m_rd_valid);
            errors++;
        end
        m_rd_done = 1'b1;
        step();
        m_rd_done = 1'b0;
        checks++;
        if (s_rd_done !== 4'b0100) begin
            $display("FAIL single_done got %b exp 0100", s_rd_done);
            errors++;
        end
        step();
        checks++;
        if (s_rd_done !== 4'b0000) begin
            $display("FAIL single_done_pulse got %b exp 0000", s_rd_done);
            errors++;
        end
    endtask

    task automatic test_wr_round_robin();
        logic [AW-1:0] exp_a [4];
        logic [LW-1:0] exp_l [4];
        exp_a[0] = AW'(33'h100); exp_a[1] = AW'(33'h200); exp_a[2] = AW'(33'h300); exp_a[3] = AW'(33'h400);
        exp_l[0] = LW'(8); exp_l[1] = LW'(16); exp_l[2] = LW'(24); exp_l[3] = LW'(0);
        for (int i = 0; i < 4; i++) set_wr(i, exp_a[i], exp_l[i]);
        m_wr_ready = 1'b1;
        s_wr_valid = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (s_wr_ready !== 4'(1 << k)) begin
                $display("FAIL rr_grant k=%0d got %b exp %b", k, s_wr_ready, 4'(1 << k));
                errors++;
            end
            step();
            checks++;
            if (m_wr_valid !== 1'b1 || m_wr_paddr !== exp_a[k] || m_wr_len !== exp_l[k]) begin
                $display("FAIL rr_issue k=%0d got v=%b a=%0h l=%0d exp v=1 a=%0h l=%0d",
                         k, m_wr_valid, m_wr_paddr, m_wr_len, exp_a[k], exp_l[k]);
                errors++;
            end
        end
        s_wr_valid = '0;
        m_wr_done = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if (s_wr_done !== 4'(1 << j)) begin
                $display("FAIL rr_done j=%0d got %b exp %b", j, s_wr_done, 4'(1 << j));
                errors++;
            end
        end
        m_wr_done = 1'b0;
        step();
        checks++;
        if (s_wr_done !== 4'b0000 || err_wr_spurious !== 1'b0) begin
            $display("FAIL rr_done_end got done=%b err=%b exp 0000 0", s_wr_done, err_wr_spurious);
            errors++;
        end
    endtask

    task automatic test_back_pressure();
        set_rd(0, AW'(33'h2000), LW'(16));
        set_rd(1, AW'(33'h3000), LW'(32));
        set_rd(3, AW'(33'h4000), LW'(48));
        m_rd_ready = 1'b0;
        s_rd_valid = 4'b1011;
        #1;
        checks++;
        if (s_rd_ready !== 4'b1000) begin
            $display("FAIL bp_first got %b exp 1000", s_rd_ready);
            errors++;
        end
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (s_rd_ready !== 4'b0000 || m_rd_valid !== 1'b1 || m_rd_paddr !== AW'(33'h4000) || m_rd_len !== LW'(48)) begin
                $display("FAIL bp_hold c=%0d got ready=%b v=%b a=%0h l=%0d exp 0000 1 4000 48",
                         c, s_rd_ready, m_rd_valid, m_rd_paddr, m_rd_len);
                errors++;
            end
            step();
        end
        m_rd_ready = 1'b1;
        #1;
        checks++;
        if (s_rd_ready !== 4'b0001) begin
            $display("FAIL bp_release got %b exp 0001", s_rd_ready);
            errors++;
        end
        step();
        checks++;
        if (m_rd_paddr !== AW'(33'h2000) || s_rd_ready !== 4'b0010) begin
            $display("FAIL bp_next0 got a=%0h ready=%b exp 2000 0010", m_rd_paddr, s_rd_ready);
            errors++;
        end
        step();
        s_rd_valid = '0;
        checks++;
        if (m_rd_paddr !== AW'(33'h3000) || m_rd_len !== LW'(32)) begin
            $display("FAIL bp_next1 got a=%0h l=%0d exp 3000 32", m_rd_paddr, m_rd_len);
            errors++;
        end
        m_rd_done = 1'b1;
        step();
        checks++;
        if (s_rd_done !== 4'b1000) begin
            $display("FAIL bp_done0 got %b exp 1000", s_rd_done);
            errors++;
        end
        step();
        checks++;
        if (s_rd_done !== 4'b0001) begin
            $display("FAIL bp_done1 got %b exp 0001", s_rd_done);
            errors++;
        end
        step();
        m_rd_done = 1'b0;
        checks++;
        if (s_rd_done !== 4'b0010) begin
            $display("FAIL bp_done2 got %b exp 0010", s_rd_done);
            errors++;
        end
        step();
    endtask

    task automatic test_full();
        set_rd(0, AW'(33'h5000), LW'(64));
        m_rd_ready = 1'b1;
        s_rd_valid = 4'b0001;
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (s_rd_ready !== 4'b0001) begin
                $display("FAIL full_fill k=%0d got %b exp 0001", k, s_rd_ready);
                errors++;
            end
            step();
        end
        checks++;
        if (s_rd_ready !== 4'b0000) begin
            $display("FAIL full_stall got %b exp 0000", s_rd_ready);
            errors++;
        end
        m_rd_done = 1'b1;
        #1;
        checks++;
        if (s_rd_ready !== 4'b0000) begin
            $display("FAIL full_prepop got %b exp 0000", s_rd_ready);
            errors++;
        end
        step();
        m_rd_done = 1'b0;
        #1;
        checks++;
        if (s_rd_done !== 4'b0001 || m_rd_valid !== 1'b0 || s_rd_ready !== 4'b0001) begin
            $display("FAIL full_after_pop got done=%b v=%b ready=%b exp 0001 0 0001", s_rd_done, m_rd_valid, s_rd_ready);
            errors++;
        end
        step();
        s_rd_valid = '0;
        checks++;
        if (m_rd_valid !== 1'b1) begin
            $display("FAIL full_ninth got v=%b exp 1", m_rd_valid);
            errors++;
        end
        m_rd_done = 1'b1;
        for (int j = 0; j < 7; j++) begin
            step();
            checks++;
            if (s_rd_done !== 4'b0001) begin
                $display("FAIL full_drain j=%0d got %b exp 0001", j, s_rd_done);
                errors++;
            end
        end
        m_rd_done = 1'b0;
        step();
    endtask

    task automatic test_spurious();
        m_wr_done = 1'b1;
        step();
        m_wr_done = 1'b0;
        checks++;
        if (s_wr_done !== 4'b0000 || err_wr_spurious !== 1'b1 || err_rd_spurious !== 1'b0) begin
            $display("FAIL spur_flag got done=%b errw=%b errr=%b exp 0000 1 0", s_wr_done, err_wr_spurious, err_rd_spurious);
            errors++;
        end
        set_rd(2, AW'(33'h6000), LW'(0));
        s_rd_valid = 4'b0100;
        #1;
        checks++;
        if (s_rd_ready !== 4'b0100) begin
            $display("FAIL spur_rd_grant got %b exp 0100", s_rd_ready);
            errors++;
        end
        step();
        s_rd_valid = '0;
        checks++;
        if (m_rd_valid !== 1'b1 || m_rd_paddr !== AW'(33'h6000) || m_rd_len !== LW'(0)) begin
            $display("FAIL spur_rd_issue got v=%b a=%0h l=%0d exp 1 6000 0", m_rd_valid, m_rd_paddr, m_rd_len);
            errors++;
        end
        step(); step(); step();
        checks++;
        if (err_wr_spurious !== 1'b1 || s_wr_done !== 4'b0000) begin
            $display("FAIL spur_sticky got errw=%b done=%b exp 1 0000", err_wr_spurious, s_wr_done);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        m_rd_ready = 1'b0;
        s_rd_valid = 4'b0010;
        #1;
        checks++;
        if (s_rd_ready !== 4'b0010) begin
            $display("FAIL rst_pre_grant got %b exp 0010", s_rd_ready);
            errors++;
        end
        step();
        s_rd_valid = '0;
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        checks++;
        if ({m_rd_valid, m_wr_valid, s_rd_done, s_wr_done, err_rd_spurious, err_wr_spurious} !== '0 ||
            m_rd_paddr !== '0 || m_rd_len !== '0) begin
            $display("FAIL rst_mid_outputs got rv=%b a=%0h l=%0d errw=%b exp 0 0 0 0",
                     m_rd_valid, m_rd_paddr, m_rd_len, err_wr_spurious);
            errors++;
        end
        m_rd_done = 1'b1;
        step();
        m_rd_done = 1'b0;
        checks++;
        if (s_rd_done !== 4'b0000 || err_rd_spurious !== 1'b1) begin
            $display("FAIL rst_stale_done got done=%b errr=%b exp 0000 1", s_rd_done, err_rd_spurious);
            errors++;
        end
        set_rd(0, AW'(33'h7000), LW'(4));
        m_rd_ready = 1'b1;
        s_rd_valid = 4'b1111;
        #1;
        checks++;
        if (s_rd_ready !== 4'b0001) begin
            $display("FAIL rst_first_client got %b exp 0001", s_rd_ready);
            errors++;
        end
        step();
        s_rd_valid = '0;
        checks++;
        if (m_rd_paddr !== AW'(33'h7000) || err_rd_spurious !== 1'b1) begin
            $display("FAIL rst_first_issue got a=%0h errr=%b exp 7000 1", m_rd_paddr, err_rd_spurious);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_wr_round_robin();
        test_back_pressure();
        test_full();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
